hdmi_pixel_lut: RTL and testbench

//  Programmable per-channel pixel lookup table (gamma / colour correction) on the HDMI

---
 rtl/hdmi_pixel_lut_if.sv | 28 ++
 rtl/hdmi_pixel_lut.sv | 126 ++++++++++++
 tb/tb_hdmi_pixel_lut.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/hdmi_pixel_lut_if.sv
// hdmi_pixel_lut_if: pixel stream, host table-write port and status of the pixel LUT
interface hdmi_pixel_lut_if #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 3,
    parameter int SYNC_W   = 3
);
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    logic                       in_valid;
    logic [CHANNELS*DATA_W-1:0] in_data;
    logic [SYNC_W-1:0]          in_sync;
    logic                       bypass;
    logic                       wr_en;
    logic [CW-1:0]              wr_chan;
    logic [DATA_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          wr_data;
    logic                       out_valid;
    logic [CHANNELS*DATA_W-1:0] out_data;
    logic [SYNC_W-1:0]          out_sync;
    logic                       ready;
    modport master (
        output in_valid, in_data, in_sync, bypass, wr_en, wr_chan, wr_addr, wr_data,
        input  out_valid, out_data, out_sync, ready
    );
    modport slave (
        input  in_valid, in_data, in_sync, bypass, wr_en, wr_chan, wr_addr, wr_data,
        output out_valid, out_data, out_sync, ready
    );
endinterface

// File: rtl/hdmi_pixel_lut.sv
// hdmi_pixel_lut: per-channel programmable pixel lookup table with delayed sideband
// and an identity-loading init sequencer after reset.
module hdmi_pixel_lut #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 3,
    parameter int LATENCY  = 2,
    parameter int SYNC_W   = 3
) (
    input logic             clk,
    input logic             rst_n,
    hdmi_pixel_lut_if.slave px_if
);
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam int PW = CHANNELS * DATA_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              init_we;
    logic              run;
    logic              acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        init_we = 1'b0;
        if (state_q == INIT) begin
            init_we = 1'b1;
            cnt_d   = cnt_q + 1'b1;
            if (&cnt_q) begin
                state_d = RUN;
                ready_d = 1'b1;
            end
        end
    end

    assign run         = state_q == RUN;
    assign acc         = px_if.in_valid && run;
    assign px_if.ready = ready_q;

    logic              vld1_q;
    logic              byp1_q;
    logic              seen_q;
    logic [PW-1:0]     pix1_q;
    logic [SYNC_W-1:0] sync1_q;
    logic [PW-1:0]     lut_rd;
    logic [PW-1:0]     sel;

    // The sideband advances every cycle; pixel fields only load on accepted pixels so they hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld1_q  <= 1'b0;
            byp1_q  <= 1'b0;
            seen_q  <= 1'b0;
            pix1_q  <= '0;
            sync1_q <= '0;
        end else begin
            vld1_q  <= acc;
            sync1_q <= px_if.in_sync;
            if (acc) begin
                byp1_q <= px_if.bypass;
                pix1_q <= px_if.in_data;
                seen_q <= 1'b1;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DATA_W-1:0] mem [2**DATA_W];
        logic [DATA_W-1:0] rd_q;
        logic              we;
        logic [DATA_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        assign we = init_we || (run && px_if.wr_en && px_if.wr_chan == CW'(c));
        assign wa = init_we ? cnt_q : px_if.wr_addr;
        assign wd = init_we ? cnt_q : px_if.wr_data;
        // Read and write share one edge, so a colliding lookup sees the old entry.
        always_ff @(posedge clk) begin
            if (we) mem[wa] <= wd;
            if (acc) rd_q <= mem[px_if.in_data[c*DATA_W +: DATA_W]];
        end
        assign lut_rd[c*DATA_W +: DATA_W] = rd_q;
    end

    // The RAM read register has no reset, so mask it until a pixel has been looked up.
    assign sel = byp1_q ? pix1_q : (seen_q ? lut_rd : '0);

    if (LATENCY == 1) begin : g_lat1
        assign px_if.out_valid = vld1_q;
        assign px_if.out_data  = sel;
        assign px_if.out_sync  = sync1_q;
    end else begin : g_lat2
        logic              ov_q;
        logic [PW-1:0]     od_q;
        logic [SYNC_W-1:0] os_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ov_q <= 1'b0;
                od_q <= '0;
                os_q <= '0;
            end else begin
                ov_q <= vld1_q;
                os_q <= sync1_q;
                if (vld1_q) od_q <= sel;
            end
        end
        assign px_if.out_valid = ov_q;
        assign px_if.out_data  = od_q;
        assign px_if.out_sync  = os_q;
    end
endmodule

// File: tb/tb_hdmi_pixel_lut.sv
// tb_hdmi_pixel_lut: directed and random checks of hdmi_pixel_lut against a table model
module tb_hdmi_pixel_lut;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nchk = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    hdmi_pixel_lut_if #(.DATA_W(8), .CHANNELS(3), .SYNC_W(3)) px ();

    hdmi_pixel_lut #(.DATA_W(8), .CHANNELS(3), .LATENCY(2), .SYNC_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .px_if (px)
    );

    logic [7:0]  tbl [3][256];
    logic        qv [$];
    logic [23:0] qd [$];
    logic [2:0]  qs [$];
    logic [23:0] hold;
    int          k;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++)
            for (int a = 0; a < 256; a++) tbl[c][a] = 8'(a);
        qv = {1'b0};
        qd = {24'h0};
        qs = {3'b0};
        hold = '0;
        k = 0;
    endtask

    // One clock: predict the output for the current inputs, then check what is due now.
    task automatic tick();
        logic        acc;
        logic        rdy;
        logic [23:0] px_in;
        px_in = px.in_data;
        acc = px.in_valid && (k >= 256);
        if (acc)
            hold = px.bypass ? px_in :
                   {tbl[2][px_in[23:16]], tbl[1][px_in[15:8]], tbl[0][px_in[7:0]]};
        qv.push_back(acc);
        qd.push_back(hold);
        qs.push_back(px.in_sync);
        if (k >= 256 && px.wr_en && px.wr_chan < 3) tbl[px.wr_chan][px.wr_addr] = px.wr_data;
        rdy = k >= 255;
        k++;
        @(posedge clk);
        #1;
        chk("out_valid", 32'(px.out_valid), 32'(qv.pop_front()));
        chk("out_data", 32'(px.out_data), 32'(qd.pop_front()));
        chk("out_sync", 32'(px.out_sync), 32'(qs.pop_front()));
        chk("ready", 32'(px.ready), 32'(rdy));
    endtask

    task automatic pix(input logic v, input logic [23:0] d);
        px.in_valid = v;
        px.in_data  = d;
    endtask

    task automatic wr(input logic en, input logic [1:0] ch, input logic [7:0] a, input logic [7:0] d);
        px.wr_en   = en;
        px.wr_chan = ch;
        px.wr_addr = a;
        px.wr_data = d;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        pix(0, 0);
        wr(0, 0, 0, 0);
        px.in_sync = 0;
        px.bypass  = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(px.out_valid), 0);
        chk("rst_data", 32'(px.out_data), 0);
        chk("rst_sync", 32'(px.out_sync), 0);
        chk("rst_ready", 32'(px.ready), 0);
        rst_n = 1'b1;
        model_reset();
        pix(1, 24'h777777);
        repeat (256) tick();
        chk("t1_ready", 32'(px.ready), 1);
        pix(1, 24'h333333);
        tick();
        pix(0, 0);
        tick();
        chk("t1_valid", 32'(px.out_valid), 1);
        chk("t1_data", 32'(px.out_data), 32'h333333);
        wr(1, 1, 8'h33, 8'hA5);
        tick();
        wr(0, 0, 0, 0);
        pix(1, 24'h333333);
        tick();
        pix(0, 0);
        tick();
        chk("t2_data", 32'(px.out_data), 32'h33A533);
        wr(1, 0, 8'h10, 8'hFF);
        pix(1, 24'h101010);
        tick();
        wr(0, 0, 0, 0);
        tick();
        chk("t3_old", 32'(px.out_data), 32'h101010);
        pix(0, 0);
        tick();
        chk("t3_new", 32'(px.out_data), 32'h1010FF);
        px.bypass  = 1;
        px.in_sync = 3'b101;
        pix(1, 24'h333333);
        tick();
        px.bypass  = 0;
        px.in_sync = 0;
        pix(0, 0);
        chk("t4_early", 32'(px.out_valid), 0);
        tick();
        chk("t4_data", 32'(px.out_data), 32'h333333);
        chk("t4_sync", 32'(px.out_sync), 32'h5);
        for (int i = 0; i < 12; i++) begin
            pix(i < 10, 24'(i * 24'h010101));
            tick();
            if (i >= 1 && i <= 10) begin
                chk("t5_valid", 32'(px.out_valid), 1);
                chk("t5_data", 32'(px.out_data), 32'((i - 1) * 24'h010101));
            end
        end
        for (int i = 0; i < 400; i++) begin
            pix($urandom_range(0, 3) != 0, ($urandom_range(0, 1) != 0) ? 24'($urandom) & 24'h0F0F0F : 24'($urandom));
            px.bypass  = $urandom_range(0, 7) == 0;
            px.in_sync = 3'($urandom);
            wr($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 15)), 8'($urandom));
            tick();
        end
        wr(0, 0, 0, 0);
        px.bypass = 0;
        for (int i = 0; i < 4; i++) begin
            pix(1, 24'($urandom));
            px.in_sync = 3'($urandom_range(1, 7));
            tick();
        end
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(px.out_valid), 0);
        chk("t6_data", 32'(px.out_data), 0);
        chk("t6_sync", 32'(px.out_sync), 0);
        chk("t6_ready", 32'(px.ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        wr(1, 1, 8'h33, 8'h77);
        pix(1, 24'h333333);
        repeat (256) tick();
        wr(0, 0, 0, 0);
        px.in_sync = 0;
        tick();
        pix(0, 0);
        tick();
        chk("t6_identity", 32'(px.out_data), 32'h333333);
        chk("t6_ivalid", 32'(px.out_valid), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
